// File: rtl/atvn_fifo_pkg.sv
// -----------------------------------------------------------------------------
// atvn_fifo_pkg
// Shared constants and helpers for the dual-port-RAM FIFO controller and its
// prefetch skid buffer.
//   ADDRBIT_DEF / DEPTH_DEF / WIDTH_DEF / WR_LAT_DEF / RD_LAT_DEF
//                 default geometry and RAM latencies
//   CNTW          width of the occupancy count (ADDRBIT + 2)
//   ptr_inc()     pointer increment with wrap at an arbitrary depth
// -----------------------------------------------------------------------------
package atvn_fifo_pkg;

    localparam int ADDRBIT_DEF = 6;
    localparam int DEPTH_DEF   = 48;
    localparam int WIDTH_DEF   = 80;
    localparam int WR_LAT_DEF  = 2;
    localparam int RD_LAT_DEF  = 2;

    // The count must hold DEPTH + SKID, which can exceed 2**ADDRBIT.
    localparam int CNTW = ADDRBIT_DEF + 2;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Small register FIFO that catches RAM read returns and presents the head
// word first-word-fall-through.
//   clk, rst       clock, synchronous active-high reset
//   push_i         write push_dat_i into the tail
//   push_dat_i     data to push
//   pop_i          drop the head entry (ignored when empty)
//   vld_o          at least one entry held
//   head_o         oldest entry
//   cnt_o          number of entries held
// -----------------------------------------------------------------------------
module fifo_skid_buf
    import atvn_fifo_pkg::*;
#(
    parameter int N     = 3,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTB  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] head_o,
    output logic [CNTB-1:0]  cnt_o
);

    localparam int              PW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTB-1:0] N_C = CNTB'(N);

    logic [WIDTH-1:0] slot_q [N];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CNTB-1:0]  cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    // A push into a full buffer is still fine if the head leaves this cycle.
    always_comb begin
        pop_ok  = pop_i & (cnt_q != '0);
        push_ok = push_i & ((cnt_q != N_C) | pop_ok);
        head_d  = pop_ok  ? PW'(ptr_inc(32'(head_q), unsigned'(N))) : head_q;
        tail_d  = push_ok ? PW'(ptr_inc(32'(tail_q), unsigned'(N))) : tail_q;
        cnt_d   = cnt_q + CNTB'(push_ok) - CNTB'(pop_ok);
        vld_o   = (cnt_q != '0);
        head_o  = slot_q[head_q];
        cnt_o   = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_q[tail_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fifo_mem2rw_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_mem2rw_ctrl
// Single-clock FIFO controller driving a dual-port RAM (port 0 write-only,
// port 1 read-only). Valid/ready write side, first-word-fall-through read
// side; RAM latency is hidden by prefetching into a RD_LAT+1 entry skid.
//   clk, rst       clock for everything, synchronous active-high reset
//   wr_vld/wr_rdy  write handshake, wr_dat write data
//   wr_drop        pulse when a write request is refused
//   rd_vld/rd_rdy  head-valid / pop handshake, rd_dat head data
//   count          entries held: RAM + reads in flight + skid
//   mem_a0/mem_we0/mem_di0   RAM write port
//   mem_a1/mem_re1/mem_do1   RAM read port (data RD_LAT cycles after strobe)
// -----------------------------------------------------------------------------
module fifo_mem2rw_ctrl
    import atvn_fifo_pkg::*;
#(
    parameter int ADDRBIT = ADDRBIT_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int WR_LAT  = WR_LAT_DEF,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_vld,
    output logic               wr_rdy,
    input  logic [WIDTH-1:0]   wr_dat,
    output logic               wr_drop,
    output logic               rd_vld,
    input  logic               rd_rdy,
    output logic [WIDTH-1:0]   rd_dat,
    output logic [ADDRBIT+1:0] count,
    output logic [ADDRBIT-1:0] mem_a0,
    output logic               mem_we0,
    output logic [WIDTH-1:0]   mem_di0,
    output logic [ADDRBIT-1:0] mem_a1,
    output logic               mem_re1,
    input  logic [WIDTH-1:0]   mem_do1
);

    localparam int            SKID    = RD_LAT + 1;
    localparam int            CW      = ADDRBIT + 2;
    localparam int            SCW     = $clog2(SKID + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SKID_C  = CW'(SKID);

    logic [ADDRBIT-1:0] wptr_q, wptr_d;
    logic [ADDRBIT-1:0] rptr_q, rptr_d;
    logic [CW-1:0]      mem_cnt_q, mem_cnt_d;
    logic [CW-1:0]      avail_q, avail_d;
    logic [WR_LAT-1:0]  commit_q, commit_d;
    logic [RD_LAT-1:0]  rdtag_q, rdtag_d;

    logic [CW-1:0]      avail_eff;
    logic [CW-1:0]      inflight;
    logic               wr_acc, rd_issue, rd_ret, pop, commit_out;
    logic               skid_vld;
    logic [SCW-1:0]     skid_cnt;
    logic [WIDTH-1:0]   skid_head;

    // Handshakes, RAM strobes and next-state arithmetic. mem_cnt tracks words
    // in the RAM not yet read; avail tracks the committed subset of those.
    always_comb begin
        wr_rdy  = ~rst & (mem_cnt_q < DEPTH_C);
        wr_acc  = wr_vld & wr_rdy;
        wr_drop = ~rst & wr_vld & ~wr_rdy;

        rd_vld  = ~rst & skid_vld;
        rd_dat  = skid_head;
        pop     = rd_vld & rd_rdy;

        // A write leaving the commit pipe is already readable this cycle,
        // which keeps empty-to-output latency at WR_LAT + RD_LAT + 1.
        commit_out = commit_q[WR_LAT-1];
        avail_eff  = avail_q + CW'(commit_out);

        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(rdtag_q[i]);
        end

        // Credit: skid plus in-flight reads must stay within SKID after this
        // edge. A same-cycle pop frees one slot, which is what lets the read
        // side sustain one word per cycle.
        rd_issue = ~rst & (avail_eff != '0) &
                   ((CW'(skid_cnt) + inflight) < (SKID_C + CW'(pop)));
        rd_ret   = rdtag_q[RD_LAT-1];

        mem_we0 = wr_acc;
        mem_a0  = rst ? '0 : wptr_q;
        mem_di0 = wr_dat;
        mem_re1 = rd_issue;
        mem_a1  = rst ? '0 : rptr_q;

        wptr_d    = wr_acc   ? ADDRBIT'(ptr_inc(32'(wptr_q), unsigned'(DEPTH))) : wptr_q;
        rptr_d    = rd_issue ? ADDRBIT'(ptr_inc(32'(rptr_q), unsigned'(DEPTH))) : rptr_q;
        mem_cnt_d = mem_cnt_q + CW'(wr_acc) - CW'(rd_issue);
        avail_d   = avail_eff - CW'(rd_issue);
        commit_d  = (commit_q << 1) | WR_LAT'(wr_acc);
        rdtag_d   = (rdtag_q << 1) | RD_LAT'(rd_issue);

        count = rst ? '0 : (mem_cnt_q + inflight + CW'(skid_cnt));
    end

    // Clearing the read tags on reset is what discards RAM data that is
    // still on its way back.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            avail_q   <= '0;
            commit_q  <= '0;
            rdtag_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            avail_q   <= avail_d;
            commit_q  <= commit_d;
            rdtag_q   <= rdtag_d;
        end
    end

    fifo_skid_buf #(
        .N     (SKID),
        .WIDTH (WIDTH),
        .CNTB  (SCW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_ret),
        .push_dat_i (mem_do1),
        .pop_i      (pop),
        .vld_o      (skid_vld),
        .head_o     (skid_head),
        .cnt_o      (skid_cnt)
    );

endmodule

// File: tb/tb_fifo_mem2rw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_mem2rw_ctrl
// Bench for fifo_mem2rw_ctrl with a behavioural RAM (2-cycle write commit,
// 2-cycle read). Accepted writes go into a scoreboard queue; a monitor pops
// and compares on every DUT pop and tracks the expected count every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_mem2rw_ctrl;
    import atvn_fifo_pkg::*;

    localparam int ADDRBIT = 6;
    localparam int DEPTH   = 48;
    localparam int WIDTH   = 80;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_vld = 1'b0;
    logic               wr_rdy;
    logic [WIDTH-1:0]   wr_dat = '0;
    logic               wr_drop;
    logic               rd_vld;
    logic               rd_rdy = 1'b0;
    logic [WIDTH-1:0]   rd_dat;
    logic [CNTW-1:0]    count;
    logic [ADDRBIT-1:0] mem_a0, mem_a1;
    logic               mem_we0, mem_re1;
    logic [WIDTH-1:0]   mem_di0, mem_do1;

    int checks   = 0;
    int failures = 0;
    int modelCnt = 0;
    int cycleNo  = 0;
    logic [WIDTH-1:0] sbQ[$];

    always #5 clk = ~clk;

    fifo_mem2rw_ctrl #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .WR_LAT  (2),
        .RD_LAT  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_vld  (wr_vld),
        .wr_rdy  (wr_rdy),
        .wr_dat  (wr_dat),
        .wr_drop (wr_drop),
        .rd_vld  (rd_vld),
        .rd_rdy  (rd_rdy),
        .rd_dat  (rd_dat),
        .count   (count),
        .mem_a0  (mem_a0),
        .mem_we0 (mem_we0),
        .mem_di0 (mem_di0),
        .mem_a1  (mem_a1),
        .mem_re1 (mem_re1),
        .mem_do1 (mem_do1)
    );

    // Behavioural RAM: a write lands one edge after its strobe, so it is
    // readable two cycles later; read data appears two cycles after mem_re1.
    // Contents and pipelines are never reset.
    logic [WIDTH-1:0]   ram [DEPTH];
    logic               wpVld = 1'b0;
    logic [ADDRBIT-1:0] wpA;
    logic [WIDTH-1:0]   wpD, rp0, rp1;

    always @(posedge clk) begin
        wpVld <= mem_we0;
        wpA   <= mem_a0;
        wpD   <= mem_di0;
        if (wpVld) ram[wpA] <= wpD;
        if (mem_re1) rp0 <= ram[mem_a1];
        rp1 <= rp0;
    end
    assign mem_do1 = rp1;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic r);
        wr_vld = v;
        wr_dat = d;
        rd_rdy = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard: pop-and-compare on each DUT pop, push on each
    // accepted write, expected occupancy every cycle, RAW hazard watch.
    always @(negedge clk) begin
        cycleNo++;
        if (cycleNo > 90000) begin
            $display("[TB] FAIL watchdog: cycle %0d exceeded limit 90000", cycleNo);
            $fatal(1, "[TB] watchdog expired");
        end
        if (rst) begin
            checkOutput("rst_count",   count,   0);
            checkOutput("rst_rd_vld",  rd_vld,  0);
            checkOutput("rst_wr_rdy",  wr_rdy,  0);
            checkOutput("rst_wr_drop", wr_drop, 0);
            checkOutput("rst_mem_we0", mem_we0, 0);
            checkOutput("rst_mem_re1", mem_re1, 0);
            checkOutput("rst_mem_a0",  mem_a0,  0);
            checkOutput("rst_mem_a1",  mem_a1,  0);
            sbQ.delete();
            modelCnt = 0;
        end else begin
            checkOutput("count", count, modelCnt);
            if (rd_vld && rd_rdy) begin
                checkOutput("sb_nonempty", sbQ.size() != 0, 1);
                if (sbQ.size() != 0) checkOutput("rd_dat", rd_dat, sbQ.pop_front());
                modelCnt--;
            end
            if (wr_vld && wr_rdy) begin
                sbQ.push_back(wr_dat);
                modelCnt++;
            end
            checkOutput("wr_drop", wr_drop, wr_vld & ~wr_rdy);
            if (mem_re1)
                checkOutput("raw_hazard",
                            (mem_we0 && mem_a0 == mem_a1) || (wpVld && wpA == mem_a1), 0);
        end
    end

    task automatic drainAll(input int maxC);
        int n;
        applyStimulus(1'b0, '0, 1'b1);
        for (n = 0; n < maxC && sbQ.size() != 0; n++) nextCycle();
        repeat (2) nextCycle();
        checkOutput("drain_done", sbQ.size(), 0);
    endtask

    task automatic testLatency();
        nextCycle();
        applyStimulus(1'b1, 80'hA5, 1'b1);
        @(negedge clk);
        checkOutput("t1_wr_rdy", wr_rdy, 1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k < 5) begin
                checkOutput("t1_rd_vld_early", rd_vld, 0);
            end else if (k == 5) begin
                checkOutput("t1_rd_vld_rise", rd_vld, 1);
                checkOutput("t1_rd_dat", rd_dat, 80'hA5);
                checkOutput("t1_count_1", count, 1);
            end else begin
                checkOutput("t1_count_0", count, 0);
                checkOutput("t1_rd_vld_fall", rd_vld, 0);
            end
            nextCycle();
        end
    endtask

    task automatic testFill();
        int acc;
        logic took;
        logic [WIDTH-1:0] val;
        acc = 0;
        val = 80'h2000;
        applyStimulus(1'b1, val, 1'b0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            took = wr_rdy;
            nextCycle();
            if (took) begin
                acc++;
                val++;
            end
            applyStimulus(1'b1, val, 1'b0);
        end
        @(negedge clk);
        checkOutput("t2_accepted", acc, 51);
        checkOutput("t2_count", count, 51);
        checkOutput("t2_wr_rdy_full", wr_rdy, 0);
        checkOutput("t2_wr_drop", wr_drop, 1);
        nextCycle();
        applyStimulus(1'b0, val, 1'b0);
        @(negedge clk);
        checkOutput("t2_drop_clear", wr_drop, 0);
        nextCycle();
        drainAll(300);
    endtask

    task automatic testStream();
        int first, last, pops, acc;
        first = -1; last = -1; pops = 0; acc = 0;
        for (int i = 0; i < 230; i++) begin
            applyStimulus(acc < 200, {16'hC3C3, 64'(acc)}, 1'b1);
            @(negedge clk);
            if (wr_vld && wr_rdy) acc++;
            if (rd_vld && rd_rdy) begin
                if (first < 0) first = i;
                last = i;
                pops++;
            end
            nextCycle();
        end
        checkOutput("t3_accepted", acc, 200);
        checkOutput("t3_pops", pops, 200);
        checkOutput("t3_first_pop", first, 5);
        checkOutput("t3_back_to_back", last - first, 199);
        drainAll(50);
    endtask

    task automatic testRandom();
        int wrote, cyc;
        logic [95:0] rnd;
        wrote = 0; cyc = 0;
        while (wrote < 10000 && cyc < 60000) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            applyStimulus(1'($urandom_range(0, 1)), rnd[WIDTH-1:0],
                          1'($urandom_range(0, 1)));
            @(negedge clk);
            if (wr_vld && wr_rdy) wrote++;
            nextCycle();
            cyc++;
        end
        checkOutput("t4_all_written", wrote, 10000);
        drainAll(300);
    endtask

    task automatic testResetInFlight();
        applyStimulus(1'b1, 80'h5A01, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 80'h5A02, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 80'h5A03, 1'b0);
        @(negedge clk);
        checkOutput("t5_rst_wr_drop", wr_drop, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t5_rd_vld", rd_vld, 0);
        checkOutput("t5_count", count, 0);
        checkOutput("t5_wr_rdy", wr_rdy, 1);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            @(negedge clk);
            checkOutput("t5_stale_dropped", rd_vld, 0);
        end
        nextCycle();
    endtask

    task automatic testEmptyPop();
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput("t6_mem_re1", mem_re1, 0);
            checkOutput("t6_rd_vld", rd_vld, 0);
            nextCycle();
        end
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_wr_rdy", wr_rdy, 1);
        checkOutput("post_rst_rd_vld", rd_vld, 0);

        $display("[TB] latency");
        testLatency();
        $display("[TB] fill to full");
        testFill();
        $display("[TB] streaming");
        testStream();
        $display("[TB] random traffic");
        testRandom();
        $display("[TB] reset with reads in flight");
        testResetInFlight();
        $display("[TB] pops on empty");
        testEmptyPop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
